// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the decryption path.
//   AES_BLOCK_W      : block width in bits (128)
//   AES_NR_128/192/256 : round counts 10/12/14
//   dec_state_t      : sequencer FSM states
//   step_sel_t       : which datapath step the shared round logic performs
//   INV_SBOX         : inverse S-box table, indexed by the byte value
//   inv_mix_columns  : InvMixColumns over a full 128-bit state
// State layout: bit 127 is the MSB of byte 0; byte k sits at row k%4,
// column k/4 (column-major, as in FIPS-197).
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NR_128  = 10;
   localparam int AES_NR_192  = 12;
   localparam int AES_NR_256  = 14;

   typedef enum logic [2:0] {
      DEC_IDLE,
      DEC_FIRST,
      DEC_ROUND,
      DEC_FINAL,
      DEC_DONE
   } dec_state_t;

   typedef enum logic [1:0] {
      STEP_FIRST,
      STEP_ROUND,
      STEP_FINAL
   } step_sel_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) multiply by a 4-bit constant (only 9, 11, 13, 14 are used).
   function automatic logic [7:0] gf_mul_c(input logic [7:0] b, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
             (m[1] ? x2 : 8'h00) ^ (m[0] ? b  : 8'h00);
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
         for (int k = 0; k < 4; k++)
            r[127-32*c-8*k -: 8] = gf_mul_c(a[k], 4'd14) ^ gf_mul_c(a[(k+1)%4], 4'd11) ^
                                   gf_mul_c(a[(k+2)%4], 4'd13) ^ gf_mul_c(a[(k+3)%4], 4'd9);
      end
      return r;
   endfunction

endpackage

// File: rtl/AddRoundKey.sv
// -----------------------------------------------------------------------------
// AddRoundKey: XOR of the state with a round key.
//   i_state : 128-bit state      i_key : 128-bit round key
//   o_state : i_state ^ i_key
// -----------------------------------------------------------------------------
module AddRoundKey (
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   output logic [127:0] o_state
);
   assign o_state = i_state ^ i_key;
endmodule

// File: rtl/DecryptionRound.sv
// -----------------------------------------------------------------------------
// DecryptionRound: one middle inverse-cipher round in the reordered form
// AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes.
//   i_state : 128-bit state      i_key : round key
//   o_state : round result
// -----------------------------------------------------------------------------
module DecryptionRound
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   output logic [127:0] o_state
);
   logic [127:0] w_ark;
   logic [127:0] w_mix;
   logic [127:0] w_shift;

   AddRoundKey  u_ark (.i_state(i_state), .i_key(i_key), .o_state(w_ark));
   assign w_mix = inv_mix_columns(w_ark);
   InvShiftRows u_isr (.i_state(w_mix), .o_state(w_shift));
   InvSubBytes  u_isb (.i_state(w_shift), .o_state(o_state));
endmodule

// File: rtl/InvShiftRows.sv
// -----------------------------------------------------------------------------
// InvShiftRows: row r of the state is rotated right by r byte positions.
//   i_state : 128-bit state      o_state : shifted state
// -----------------------------------------------------------------------------
module InvShiftRows (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   // out[row r][col c] = in[row r][col (c - r) mod 4]; byte index = 4*col + row.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
   end
endmodule

// File: rtl/InvSubBytes.sv
// -----------------------------------------------------------------------------
// InvSubBytes: inverse S-box applied to each of the 16 state bytes.
//   i_state : 128-bit state      o_state : substituted state
// -----------------------------------------------------------------------------
module InvSubBytes
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   for (genvar k = 0; k < 16; k++) begin : g_byte
      assign o_state[127-8*k -: 8] = INV_SBOX[i_state[127-8*k -: 8]];
   end
endmodule

// File: rtl/aes_dec_step.sv
// -----------------------------------------------------------------------------
// aes_dec_step: the single shared combinational step of the inverse cipher.
//   i_st       : current state
//   i_rk       : round key for this step
//   i_step_sel : STEP_FIRST -> InvSubBytes(InvShiftRows(st ^ rk))
//                STEP_ROUND -> DecryptionRound(st, rk)
//                STEP_FINAL -> st ^ rk
//   o_st       : next state
// -----------------------------------------------------------------------------
module aes_dec_step
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] i_st,
   input  logic [AES_BLOCK_W-1:0] i_rk,
   input  step_sel_t              i_step_sel,
   output logic [AES_BLOCK_W-1:0] o_st
);
   logic [AES_BLOCK_W-1:0] w_ark;
   logic [AES_BLOCK_W-1:0] w_shift;
   logic [AES_BLOCK_W-1:0] w_first;
   logic [AES_BLOCK_W-1:0] w_round;

   AddRoundKey     u_ark   (.i_state(i_st), .i_key(i_rk), .o_state(w_ark));
   InvShiftRows    u_isr   (.i_state(w_ark), .o_state(w_shift));
   InvSubBytes     u_isb   (.i_state(w_shift), .o_state(w_first));
   DecryptionRound u_round (.i_state(i_st), .i_key(i_rk), .o_state(w_round));

   always_comb begin
      o_st = w_ark;
      case (i_step_sel)
         STEP_FIRST: o_st = w_first;
         STEP_ROUND: o_st = w_round;
         default:    o_st = w_ark;
      endcase
   end
endmodule

// File: rtl/aes_decrypt_sequencer.sv
// -----------------------------------------------------------------------------
// aes_decrypt_sequencer: iterative AES inverse cipher, one step per clock.
//   clk, reset : clock, synchronous active-high reset
//   in_valid / in_ready / in_data    : ciphertext input handshake
//   rk_idx / rk                      : round-key store address / key (same cycle)
//   out_valid / out_ready / out_data : plaintext output handshake
//   busy       : high while FIRST, ROUND or FINAL is running
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and out_valid/out_data stay stable
// until the transfer completes.
// Sequence: FIRST (key NR), ROUND x NR-1 (keys NR-1..1), FINAL (key 0), DONE.
// -----------------------------------------------------------------------------
module aes_decrypt_sequencer
   import aes_pkg::*;
#(
   parameter int NR = AES_NR_128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   output logic [3:0]             rk_idx,
   input  logic [AES_BLOCK_W-1:0] rk,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   busy
);
   if (!(NR == AES_NR_128 || NR == AES_NR_192 || NR == AES_NR_256)) begin : g_bad_nr
      $error("aes_decrypt_sequencer: NR must be 10, 12 or 14");
   end

   localparam logic [3:0] NR_L  = 4'(NR);
   localparam logic [3:0] NR_M1 = 4'(NR - 1);

   dec_state_t             r_state;
   dec_state_t             w_next_state;
   logic [AES_BLOCK_W-1:0] r_st;
   logic [3:0]             r_cnt;
   logic [AES_BLOCK_W-1:0] w_step_out;
   step_sel_t              w_step_sel;
   logic                   w_accept;

   // in_ready is only ever high in IDLE, so this is in_valid & in_ready.
   assign w_accept = in_valid && (r_state == DEC_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= DEC_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic. ROUND exits at cnt==1 so the counter never wraps.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DEC_IDLE:  if (w_accept) w_next_state = DEC_FIRST;
         DEC_FIRST: w_next_state = DEC_ROUND;
         DEC_ROUND: if (r_cnt == 4'd1) w_next_state = DEC_FINAL;
         DEC_FINAL: w_next_state = DEC_DONE;
         DEC_DONE:  if (out_ready) w_next_state = DEC_IDLE;
         default:   w_next_state = DEC_IDLE;
      endcase
   end

   // Output decode from registered state, st and cnt only.
   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      rk_idx     = 4'd0;
      w_step_sel = STEP_FINAL;
      case (r_state)
         DEC_IDLE:  in_ready = 1'b1;
         DEC_FIRST: begin busy = 1'b1; rk_idx = NR_L;  w_step_sel = STEP_FIRST; end
         DEC_ROUND: begin busy = 1'b1; rk_idx = r_cnt; w_step_sel = STEP_ROUND; end
         DEC_FINAL: begin busy = 1'b1; rk_idx = 4'd0;  w_step_sel = STEP_FINAL; end
         DEC_DONE:  begin out_valid = 1'b1; out_data = r_st; end
         default:   ;
      endcase
   end

   aes_dec_step u_step (
      .i_st      (r_st),
      .i_rk      (rk),
      .i_step_sel(w_step_sel),
      .o_st      (w_step_out)
   );

   // Datapath: st and cnt only move in IDLE (on accept) and while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st  <= '0;
         r_cnt <= 4'd0;
      end else begin
         case (r_state)
            DEC_IDLE: if (w_accept) begin
               r_st  <= in_data;
               r_cnt <= NR_L;
            end
            DEC_FIRST: begin
               r_st  <= w_step_out;
               r_cnt <= NR_M1;
            end
            DEC_ROUND: begin
               r_st  <= w_step_out;
               r_cnt <= r_cnt - 4'd1;
            end
            DEC_FINAL: r_st <= w_step_out;
            default:   ;
         endcase
      end
   end
endmodule

// File: doc/aes_decrypt_sequencer.md
# aes_decrypt_sequencer

Iterative AES decryption controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and runs the inverse cipher on a single shared combinational round datapath (the existing `DecryptionRound` plus the first-step and final-step logic), one step per clock. Round keys come from an external round-key store, addressed by an index this block drives, highest key first. The block sits between the ciphertext source and the plaintext sink, under the AES top.

## Interface
Parameters:
- `NR`, default 10: number of cipher rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is a compile-time error.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: ciphertext available on `in_data`.
- `in_ready`, output, 1: block can accept a ciphertext. It is high only in IDLE.
- `in_data`, input, 128: ciphertext, bit 127 = byte 0 MSB.
- `rk_idx`, output, 4: round-key index requested this cycle.
- `rk`, input, 128: round key `rk_idx`. It is valid combinationally in the same cycle (array lookup).
- `out_valid`, output, 1: plaintext available on `out_data`.
- `out_ready`, input, 1: sink accepts the plaintext.
- `out_data`, output, 128: plaintext, registered.
- `busy`, output, 1: high in FIRST, ROUND and FINAL.

## Operation
- States: IDLE, FIRST, ROUND, FINAL, DONE. All outputs are decoded from the registered state, the 128-bit `st` register and the 4-bit `cnt` counter.
- IDLE: `in_ready`=1 and `rk_idx`=0. On `in_valid & in_ready`: `st <= in_data`, `cnt <= NR`, go to FIRST.
- FIRST: `rk_idx`=NR. `st <= InvSubBytes(InvShiftRows(st ^ rk))`, `cnt <= NR-1`, go to ROUND.
- ROUND: `rk_idx`=`cnt`. `st <= DecryptionRound(st, rk)` (AddRoundKey, then InvMixColumns, InvShiftRows, InvSubBytes), `cnt <= cnt-1`. When `cnt`==1, go to FINAL. This runs NR-1 cycles, with key indices NR-1 down to 1.
- FINAL: `rk_idx`=0. `st <= st ^ rk`, go to DONE.
- DONE: `out_valid`=1 and `out_data`=`st`. On `out_ready`, go to IDLE. Both `out_valid` and `out_data` are held stable while `out_ready`=0.
- No overlap: `in_valid` outside IDLE is ignored and has no effect on `st`.
- `cnt` never wraps, because the FSM leaves ROUND at `cnt`==1.
- `rk_idx` is 0 in IDLE and DONE.
- The `rk` value is sampled only in FIRST, ROUND and FINAL.
- Reset values (applied at the clock edge where `reset`=1): state IDLE, `st`=0, `cnt`=0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `rk_idx`=0.
- Reset mid-operation in any state aborts the block. No output is produced, and the next accepted block decrypts correctly.
- Simultaneous `reset` and `in_valid`: reset wins and the input is not accepted.

## Timing
- Handshake on ciphertext input: accept at edge E0.
- FIRST: cycle 1.
- ROUND: cycles 2 to NR.
- FINAL: cycle NR+1.
- `out_valid` is first high in cycle NR+2. That is 12 cycles for NR=10 and 16 cycles for NR=14.
- Output handshake at edge Ek puts the block in IDLE at cycle k+1. Minimum block spacing is NR+3 cycles.
- The critical path is one `DecryptionRound` plus the `rk` lookup and the step mux, within one cycle.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_W`=128
  - `AES_NR_128/192/256` = 10/12/14
  - `dec_state_t` enum (IDLE, FIRST, ROUND, FINAL, DONE)
  - `step_sel_t` (FIRST, ROUND, FINAL)
- Sub-module `aes_dec_step` (combinational), with inputs `st`, `rk` and `step_sel`:
  - FIRST selects `InvSubBytes(InvShiftRows(st^rk))`.
  - ROUND selects `DecryptionRound`.
  - FINAL selects `AddRoundKey`.
  - It reuses the existing `AddRoundKey`, `InvShiftRows`, `InvSubBytes` and `DecryptionRound` modules.
- The FSM, counter and handshake logic live in `aes_decrypt_sequencer`.

## Test plan
1. FIPS-197 C.1 (NR=10, key 000102…0f, bench-modelled key store): ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `out_data` 00112233445566778899aabbccddeeff in cycle 12. Observed `rk_idx` sequence is 10, 9, …, 1, 0, and `busy` is high for 11 cycles.
2. FIPS-197 B (key 2b7e151628aed2a6abf7158809cf4f3c): ciphertext 3925841d02dc09fbdc118597196a0b32 with `out_ready` held 0 for 5 cycles → `out_data` 3243f6a8885a308d313198a2e0370734 held stable with `out_valid`=1 and `in_ready`=0 throughout. After the handshake, `in_ready`=1 the next cycle.
3. Back-to-back: `in_valid`=1 continuously with blocks from tests 1 and 2, `out_ready`=1 → second acceptance exactly 13 cycles after the first, both results correct.
4. `in_valid` pulsed with ffff…ff during ROUND → result unaffected and the block is not accepted later.
5. `reset` asserted for 1 cycle in the 5th ROUND cycle → next cycle IDLE with `out_valid`=0, `out_data`=0, `in_ready`=1. Test 1 then rerun passes.
6. NR=14 build, FIPS-197 C.3: ciphertext 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff in cycle 16, `rk_idx` 14 down to 0.
